// File: rtl/ram_bus_arbiter_if.sv
// Signal bundle around the RAM bus arbiter. It carries the loader handshake,
// the Z80 bus-request pair, the CPU-side RAM signals and the RAM port.
interface ram_bus_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_wdata;
  logic              ld_ack;
  logic [7:0]        ld_rdata;
  logic              ld_err;
  logic              nBUSRQ;
  logic              nBUSACK;
  logic              bus_owner;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_wren;
  logic [ADDR_W-1:0] ram_address;
  logic [7:0]        ram_data;
  logic              ram_wren;
  logic [7:0]        ram_q;

  // Arbiter side: it serves the loader and drives the RAM port.
  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata, nBUSACK,
    input  cpu_addr, cpu_wdata, cpu_wren, ram_q,
    output ld_ack, ld_rdata, ld_err, nBUSRQ, bus_owner,
    output ram_address, ram_data, ram_wren
  );

  // Environment side: loader, CPU glue and RAM.
  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata, nBUSACK,
    output cpu_addr, cpu_wdata, cpu_wren, ram_q,
    input  ld_ack, ld_rdata, ld_err, nBUSRQ, bus_owner,
    input  ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Shares the 16K synchronous RAM between the A-Z80 CPU and a loader/debug
// master. Bus ownership is obtained through nBUSRQ/nBUSACK. Once the bus is
// granted, loader accesses are performed one at a time. The bus is handed back
// to the CPU after HOLD_CYCLES idle cycles.
module ram_bus_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int HOLD_CYCLES = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  ram_bus_arbiter_if.slave bus
);

  localparam int CNT_MAX = (ACK_TIMEOUT > HOLD_CYCLES) ? ACK_TIMEOUT : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    WRITE,
    READ_A,
    READ_D,
    RELEASE
  } arbState;

  arbState           state;
  arbState           nextState;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] heldAddr;
  logic [7:0]        heldData;
  logic              heldWren;
  logic [7:0]        rdata;
  logic              ackPulse;
  logic              errPulse;
  logic              countInc;
  logic              acceptWrite;
  logic              acceptRead;
  logic              setAck;
  logic              setErr;
  logic              captureRead;
  logic              ownsBus;

  // State register.
  // NOTE: sequential logic uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Shared REQ-timeout / GRANT-idle counter: saturating, cleared on every state entry.
  always_ff @(posedge clk) begin
    if (!reset)                                count <= '0;
    else if (nextState != state)               count <= '0;
    else if (countInc && (count != {CNT_W{1'b1}})) count <= count + 1'b1;
  end

  // Loader access registers, acknowledge/error pulses and read-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      heldAddr <= '0;
      heldData <= '0;
      heldWren <= 1'b0;
      rdata    <= '0;
      ackPulse <= 1'b0;
      errPulse <= 1'b0;
    end else begin
      heldWren <= acceptWrite;
      ackPulse <= setAck;
      errPulse <= setErr;
      if (acceptWrite || acceptRead) heldAddr <= bus.ld_addr;
      if (acceptWrite)               heldData <= bus.ld_wdata;
      if (captureRead)               rdata    <= bus.ram_q;
    end
  end

  // Next-state and control decode. Losing nBUSACK while the bus is owned takes priority.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    nextState   = state;
    countInc    = 1'b0;
    acceptWrite = 1'b0;
    acceptRead  = 1'b0;
    setAck      = 1'b0;
    setErr      = 1'b0;
    captureRead = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ld_req) nextState = REQ;
      end
      REQ: begin
        if (!bus.nBUSACK) begin
          nextState = GRANT;
        end else if (count == ACK_LAST) begin
          nextState = RELEASE;
          setErr    = 1'b1;
        end else begin
          countInc = 1'b1;
        end
      end
      GRANT: begin
        if (bus.nBUSACK) begin
          nextState = IDLE;
          setErr    = 1'b1;
        end else if (!ackPulse) begin
          // The loader still holds ld_req during the ack cycle, so requests are only taken after it.
          if (bus.ld_req && bus.ld_we) begin
            nextState   = WRITE;
            acceptWrite = 1'b1;
          end else if (bus.ld_req) begin
            nextState  = READ_A;
            acceptRead = 1'b1;
          end else if (count == HOLD_LAST) begin
            nextState = RELEASE;
          end else begin
            countInc = 1'b1;
          end
        end
      end
      WRITE: begin
        if (bus.nBUSACK) begin
          nextState = IDLE;
          setErr    = 1'b1;
        end else begin
          nextState = GRANT;
          setAck    = 1'b1;
        end
      end
      READ_A: begin
        if (bus.nBUSACK) begin
          nextState = IDLE;
          setErr    = 1'b1;
        end else begin
          nextState = READ_D;
        end
      end
      READ_D: begin
        if (bus.nBUSACK) begin
          nextState = IDLE;
          setErr    = 1'b1;
        end else begin
          nextState   = GRANT;
          setAck      = 1'b1;
          captureRead = 1'b1;
        end
      end
      RELEASE: begin
        if (bus.nBUSACK) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign ownsBus = (state == GRANT) || (state == WRITE) ||
                   (state == READ_A) || (state == READ_D);

  // Holding reset low forces CPU pass-through at once, so an in-flight loader write never lands.
  assign bus.bus_owner = reset & ownsBus;
  assign bus.nBUSRQ    = ~(reset & (ownsBus | (state == REQ)));

  assign bus.ram_address = bus.bus_owner ? heldAddr : bus.cpu_addr;
  assign bus.ram_data    = bus.bus_owner ? heldData : bus.cpu_wdata;
  assign bus.ram_wren    = bus.bus_owner ? heldWren : bus.cpu_wren;

  assign bus.ld_ack   = ackPulse;
  assign bus.ld_err   = errPulse;
  assign bus.ld_rdata = rdata;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter. It combines a table of CPU
// pass-through vectors, a burst table, and hand-written sequences. The
// sequences cover write, read-back, hold/release, ack timeout, grant loss and
// reset during a write.
module tb_ram_bus_arbiter;

  localparam int ADDR_W = 14;
  localparam int HOLD   = 4;
  localparam int TMO    = 255;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  ram_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  ram_bus_arbiter #(
    .ADDR_W     (ADDR_W),
    .HOLD_CYCLES(HOLD),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Registered-address RAM model: q reflects the address presented at the previous edge.
  logic [7:0] mem [0:(1<<ADDR_W)-1] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_address];
  end

  // Event monitors sampled on the active edge.
  int wrenCount = 0;
  int ackCount  = 0;
  int errCount  = 0;
  int bothCount = 0;
  always @(posedge clk) begin
    if (bus.ram_wren === 1'b1)                         wrenCount++;
    if (bus.ld_ack === 1'b1)                           ackCount++;
    if (bus.ld_err === 1'b1)                           errCount++;
    if (bus.ld_ack === 1'b1 && bus.ld_err === 1'b1)    bothCount++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Move to the next cycle; outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              wren;
    logic [ADDR_W-1:0] expAddr;
    logic [7:0]        expData;
    logic              expWren;
  } passVec;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                expLatency;
  } burstVec;

  passVec  passVecs  [4];
  burstVec burstVecs [3];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int w0;
    int a0;
    int e0;
    logic lowOk;
    logic [ADDR_W-1:0] ra;

    passVecs[0] = '{14'h3F00, 8'h3C, 1'b0, 14'h3F00, 8'h3C, 1'b0};
    passVecs[1] = '{14'h0001, 8'hFF, 1'b1, 14'h0001, 8'hFF, 1'b1};
    passVecs[2] = '{14'h2AAA, 8'h00, 1'b0, 14'h2AAA, 8'h00, 1'b0};
    passVecs[3] = '{14'h1555, 8'h81, 1'b1, 14'h1555, 8'h81, 1'b1};

    burstVecs[0] = '{14'h0000, 8'h11, 3};
    burstVecs[1] = '{14'h0001, 8'h22, 3};
    burstVecs[2] = '{14'h0002, 8'h33, 3};

    // Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      ra            = ADDR_W'($urandom);
      bus.cpu_addr  = ra;
      bus.cpu_wdata = 8'($urandom);
      bus.cpu_wren  = 1'($urandom);
      bus.ld_req    = 1'($urandom);
      bus.ld_we     = 1'($urandom);
      bus.ld_addr   = ADDR_W'($urandom);
      bus.ld_wdata  = 8'($urandom);
      bus.nBUSACK   = 1'($urandom);
      tick();
      check("reset nBUSRQ", bus.nBUSRQ, 1);
      check("reset bus_owner", bus.bus_owner, 0);
      check("reset ld_ack", bus.ld_ack, 0);
      check("reset ld_err", bus.ld_err, 0);
      check("reset ld_rdata", bus.ld_rdata, 8'h00);
      check("reset ram_address", bus.ram_address, ra);
    end

    bus.ld_req    = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_wdata  = '0;
    bus.nBUSACK   = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wren  = 1'b0;
    reset         = 1'b1;
    tick();

    // CPU pass-through table while the arbiter is idle.
    foreach (passVecs[i]) begin
      bus.cpu_addr  = passVecs[i].addr;
      bus.cpu_wdata = passVecs[i].data;
      bus.cpu_wren  = passVecs[i].wren;
      #1;
      check($sformatf("pass %0d ram_address", i), bus.ram_address, passVecs[i].expAddr);
      check($sformatf("pass %0d ram_data", i), bus.ram_data, passVecs[i].expData);
      check($sformatf("pass %0d ram_wren", i), bus.ram_wren, passVecs[i].expWren);
      check($sformatf("pass %0d bus_owner", i), bus.bus_owner, 0);
      check($sformatf("pass %0d nBUSRQ", i), bus.nBUSRQ, 1);
      tick();
    end
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wren  = 1'b0;

    // Single write of 0xA5 to 0x1234; the CPU acknowledges 3 cycles after nBUSRQ falls.
    w0 = wrenCount;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 14'h1234;
    bus.ld_wdata = 8'hA5;
    bus.ld_req   = 1'b1;
    tick();
    check("request latency nBUSRQ", bus.nBUSRQ, 0);
    check("request bus_owner", bus.bus_owner, 0);
    tick();
    tick();
    tick();
    bus.nBUSACK = 1'b0;
    tick();
    check("grant bus_owner", bus.bus_owner, 1);
    check("grant ram_wren", bus.ram_wren, 0);
    tick();
    check("write ram_wren", bus.ram_wren, 1);
    check("write ram_address", bus.ram_address, 14'h1234);
    check("write ram_data", bus.ram_data, 8'hA5);
    check("write early ld_ack", bus.ld_ack, 0);
    tick();
    check("write ld_ack", bus.ld_ack, 1);
    check("write ram_wren after", bus.ram_wren, 0);
    check("write ld_err", bus.ld_err, 0);

    // Read-back of 0x1234, presented during the ack cycle and accepted in the next one.
    bus.ld_we = 1'b0;
    tick();
    check("ack pulse width", bus.ld_ack, 0);
    check("single write commit", wrenCount - w0, 1);
    tick();
    check("read_a ram_address", bus.ram_address, 14'h1234);
    check("read_a ram_wren", bus.ram_wren, 0);
    tick();
    check("read_d ld_ack", bus.ld_ack, 0);
    tick();
    check("read ld_ack", bus.ld_ack, 1);
    check("read ld_rdata", bus.ld_rdata, 8'hA5);
    check("read no ram_wren", wrenCount - w0, 1);

    // Three back-to-back writes, then idle until the bus is released.
    w0    = wrenCount;
    lowOk = 1'b1;
    foreach (burstVecs[i]) begin
      bus.ld_we    = 1'b1;
      bus.ld_addr  = burstVecs[i].addr;
      bus.ld_wdata = burstVecs[i].data;
      n = 0;
      do begin
        tick();
        n++;
        if (bus.nBUSRQ !== 1'b0) lowOk = 1'b0;
      end while (bus.ld_ack !== 1'b1 && n < 20);
      check($sformatf("burst %0d ack latency", i), n, burstVecs[i].expLatency);
    end
    bus.ld_req = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.nBUSRQ !== 1'b1 && n < 20);
    check("burst nBUSRQ held low", lowOk, 1);
    check("hold release delay", n, HOLD + 1);
    check("release bus_owner", bus.bus_owner, 0);
    check("burst write count", wrenCount - w0, 3);
    foreach (burstVecs[i]) check($sformatf("burst %0d ram content", i), mem[burstVecs[i].addr], burstVecs[i].data);
    bus.cpu_addr = 14'h0ABC;
    #1;
    check("release ram_address follows cpu", bus.ram_address, 14'h0ABC);
    bus.nBUSACK = 1'b1;
    tick();
    check("idle nBUSRQ after release", bus.nBUSRQ, 1);

    // Acknowledge timeout: nBUSACK never falls.
    w0 = wrenCount;
    e0 = errCount;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 14'h0100;
    bus.ld_wdata = 8'hEE;
    bus.ld_req   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ld_err !== 1'b1 && n < TMO + 10);
    check("timeout ld_err latency", n, TMO + 1);
    check("timeout nBUSRQ", bus.nBUSRQ, 1);
    check("timeout bus_owner", bus.bus_owner, 0);
    check("timeout ld_ack", bus.ld_ack, 0);
    bus.ld_req = 1'b0;
    tick();
    check("timeout ld_err pulse width", bus.ld_err, 0);
    tick();
    check("timeout single ld_err", errCount - e0, 1);
    check("timeout no ram_wren", wrenCount - w0, 0);
    check("timeout idle nBUSRQ", bus.nBUSRQ, 1);

    // Grant loss: nBUSACK rises during READ_A.
    a0 = ackCount;
    e0 = errCount;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 14'h0002;
    bus.ld_req  = 1'b1;
    tick();
    check("loss request nBUSRQ", bus.nBUSRQ, 0);
    bus.nBUSACK = 1'b0;
    tick();
    check("loss grant bus_owner", bus.bus_owner, 1);
    tick();
    check("loss read_a ram_address", bus.ram_address, 14'h0002);
    bus.nBUSACK = 1'b1;
    tick();
    check("loss ld_err", bus.ld_err, 1);
    check("loss ld_ack", bus.ld_ack, 0);
    check("loss bus_owner", bus.bus_owner, 0);
    check("loss nBUSRQ", bus.nBUSRQ, 1);
    bus.ld_req = 1'b0;
    tick();
    check("loss ld_err pulse width", bus.ld_err, 0);
    check("loss ld_rdata kept", bus.ld_rdata, 8'hA5);
    check("loss no ld_ack", ackCount - a0, 0);
    check("loss single ld_err", errCount - e0, 1);

    // Reset pulse arriving during a WRITE cycle suppresses the write.
    w0 = wrenCount;
    a0 = ackCount;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 14'h0200;
    bus.ld_wdata = 8'h5A;
    bus.ld_req   = 1'b1;
    tick();
    bus.nBUSACK = 1'b0;
    tick();
    tick();
    check("reset-write in-flight ram_wren", bus.ram_wren, 1);
    reset      = 1'b0;
    bus.ld_req = 1'b0;
    #1;
    check("reset-write ram_wren gated", bus.ram_wren, 0);
    check("reset-write bus_owner", bus.bus_owner, 0);
    check("reset-write nBUSRQ", bus.nBUSRQ, 1);
    check("reset-write ram_address", bus.ram_address, 14'h0ABC);
    tick();
    tick();
    check("reset-write ld_ack", bus.ld_ack, 0);
    reset       = 1'b1;
    bus.nBUSACK = 1'b1;
    tick();
    tick();
    check("reset-write nBUSRQ after", bus.nBUSRQ, 1);
    check("reset-write no ram_wren", wrenCount - w0, 0);
    check("reset-write no ld_ack", ackCount - a0, 0);

    check("ld_ack and ld_err never together", bothCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
